// File: rtl/dso_ctrl_panel.sv
// dso_ctrl_panel: debounced front-panel keys driving the DSO trigger/decimation/edge/scale/run config.
// Optional build macro DSO_CTRL_REPEAT_EN adds auto-repeat on held up/down keys.

module dso_ctrl_deb #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rdy_i,
    input  logic key_i,
    output logic stable_o,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d, prev_q, arm_q, arm_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) stable_d = sync_q[1];
            else                              cnt_d    = cnt_q + CW'(1);
        end
        // A key held through reset must be seen released before its press counts.
        arm_d = arm_q | (rdy_i & ~sync_q[1]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            arm_q    <= arm_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = stable_q & ~prev_q & arm_q;
endmodule

module dso_ctrl_panel #(
    parameter int DEB_CYCLES        = 1_000_000,
    parameter int REPEAT_DLY_CYCLES = 25_000_000,
    parameter int REPEAT_PER_CYCLES = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_sel,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_run,
    output logic [7:0] trig_level,
    output logic [9:0] deci_rate,
    output logic       trig_edge,
    output logic [4:0] v_scale,
    output logic       wave_run,
    output logic [1:0] sel_item,
    output logic       cfg_update
);
    localparam int NK = 4;  // lanes: 0 run, 1 sel, 2 up, 3 down

    typedef enum logic [1:0] {S_TRIG = 2'd0, S_DECI = 2'd1, S_EDGE = 2'd2, S_VSCALE = 2'd3} sel_t;

    logic [NK-1:0] keys, stable, press;
    logic [1:0]    rdy_q;
    logic          up_ev, dn_ev;

    assign keys = {key_down, key_up, key_sel, key_run};

    dso_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NK-1:0] (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .rdy_i   (rdy_q[1]),
        .key_i   (keys),
        .stable_o(stable),
        .press_o (press)
    );

`ifdef DSO_CTRL_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY_CYCLES > REPEAT_PER_CYCLES) ? REPEAT_DLY_CYCLES : REPEAT_PER_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    logic          rpt_act_q, rpt_act_d, rpt_dn_q, rpt_dn_d, rpt_first_q, rpt_first_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_held, rpt_ev;
    logic          stable_unused;

    assign stable_unused = ^stable[1:0];
    assign rpt_held      = rpt_dn_q ? stable[3] : stable[2];
    assign rpt_ev        = rpt_act_q & rpt_held &
                           (rpt_cnt_q == (rpt_first_q ? RW'(REPEAT_DLY_CYCLES) : RW'(REPEAT_PER_CYCLES)));

    // rpt_cnt_q holds cycles elapsed since the last up/down event of the held key.
    always_comb begin
        rpt_act_d   = rpt_act_q;
        rpt_dn_d    = rpt_dn_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        if (press[0] || press[1]) begin
            rpt_act_d = 1'b0;
        end else if (press[2] || press[3]) begin
            rpt_act_d   = 1'b1;
            rpt_dn_d    = ~press[2];
            rpt_first_d = 1'b1;
            rpt_cnt_d   = RW'(1);
        end else if (!rpt_held) begin
            rpt_act_d = 1'b0;
        end else if (rpt_ev) begin
            rpt_first_d = 1'b0;
            rpt_cnt_d   = RW'(1);
        end else if (rpt_act_q) begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rpt_act_q   <= 1'b0;
            rpt_dn_q    <= 1'b0;
            rpt_first_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_act_q   <= rpt_act_d;
            rpt_dn_q    <= rpt_dn_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    assign up_ev = press[2] | (rpt_ev & ~rpt_dn_q);
    assign dn_ev = press[3] | (rpt_ev & rpt_dn_q);
`else
    logic        stable_unused;
    logic [31:0] rpt_cfg_unused;

    assign stable_unused  = ^stable;
    assign rpt_cfg_unused = 32'(REPEAT_DLY_CYCLES + REPEAT_PER_CYCLES);
    assign up_ev          = press[2];
    assign dn_ev          = press[3];
`endif

    function automatic logic [9:0] deci_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 10'd1;
            4'd1:    return 10'd2;
            4'd2:    return 10'd5;
            4'd3:    return 10'd10;
            4'd4:    return 10'd20;
            4'd5:    return 10'd50;
            4'd6:    return 10'd100;
            4'd7:    return 10'd200;
            4'd8:    return 10'd500;
            default: return 10'd1000;
        endcase
    endfunction

    function automatic logic [4:0] vs_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    return 5'b01000;
            3'd1:    return 5'b00100;
            3'd2:    return 5'b00010;
            3'd3:    return 5'b10001;
            3'd4:    return 5'b10010;
            3'd5:    return 5'b10100;
            default: return 5'b11000;
        endcase
    endfunction

    sel_t       state_q, state_d;
    logic [7:0] trig_q, trig_d;
    logic [3:0] deci_idx_q, deci_idx_d;
    logic [9:0] deci_q, deci_d;
    logic       edge_q, edge_d, run_q, run_d, upd_q, upd_d;
    logic [2:0] vs_idx_q, vs_idx_d;
    logic [4:0] vs_q, vs_d;

    // Priority run > sel > up > down; losers in the same cycle are dropped.
    always_comb begin
        state_d    = state_q;
        trig_d     = trig_q;
        deci_idx_d = deci_idx_q;
        edge_d     = edge_q;
        vs_idx_d   = vs_idx_q;
        run_d      = run_q;
        if (press[0]) begin
            run_d = ~run_q;
        end else if (press[1]) begin
            state_d = sel_t'(state_q + 2'd1);
        end else if (up_ev || dn_ev) begin
            case (state_q)
                S_TRIG:
                    if (up_ev) trig_d = (trig_q > 8'd247) ? 8'd255 : trig_q + 8'd8;
                    else       trig_d = (trig_q < 8'd8)   ? 8'd0   : trig_q - 8'd8;
                S_DECI:
                    if (up_ev) begin
                        if (deci_idx_q != 4'd9) deci_idx_d = deci_idx_q + 4'd1;
                    end else if (deci_idx_q != 4'd0) begin
                        deci_idx_d = deci_idx_q - 4'd1;
                    end
                S_EDGE:
                    edge_d = up_ev;
                default:
                    if (up_ev) begin
                        if (vs_idx_q != 3'd6) vs_idx_d = vs_idx_q + 3'd1;
                    end else if (vs_idx_q != 3'd0) begin
                        vs_idx_d = vs_idx_q - 3'd1;
                    end
            endcase
        end
        deci_d = deci_lut(deci_idx_d);
        vs_d   = vs_lut(vs_idx_d);
        upd_d  = (trig_d != trig_q) | (deci_d != deci_q) | (edge_d != edge_q) |
                 (vs_d != vs_q) | (run_d != run_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdy_q      <= '0;
            state_q    <= S_TRIG;
            trig_q     <= 8'd127;
            deci_idx_q <= 4'd0;
            deci_q     <= 10'd1;
            edge_q     <= 1'b1;
            vs_idx_q   <= 3'd4;
            vs_q       <= 5'b10010;
            run_q      <= 1'b1;
            upd_q      <= 1'b0;
        end else begin
            rdy_q      <= {rdy_q[0], 1'b1};
            state_q    <= state_d;
            trig_q     <= trig_d;
            deci_idx_q <= deci_idx_d;
            deci_q     <= deci_d;
            edge_q     <= edge_d;
            vs_idx_q   <= vs_idx_d;
            vs_q       <= vs_d;
            run_q      <= run_d;
            upd_q      <= upd_d;
        end
    end

    assign trig_level = trig_q;
    assign deci_rate  = deci_q;
    assign trig_edge  = edge_q;
    assign v_scale    = vs_q;
    assign wave_run   = run_q;
    assign sel_item   = state_q;
    assign cfg_update = upd_q;
endmodule

// File: tb/tb_dso_ctrl_panel.sv
// Directed bench for dso_ctrl_panel with short debounce/repeat timing; expectations follow DSO_CTRL_REPEAT_EN.

module tb_dso_ctrl_panel;
    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 5;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_sel = 1'b0, key_up = 1'b0, key_down = 1'b0, key_run = 1'b0;
    logic [7:0] trig_level;
    logic [9:0] deci_rate;
    logic       trig_edge;
    logic [4:0] v_scale;
    logic       wave_run;
    logic [1:0] sel_item;
    logic       cfg_update;

    int tests = 0, fails = 0, pulses = 0;

    always #5 sys_clk = ~sys_clk;

    dso_ctrl_panel #(.DEB_CYCLES(DEB), .REPEAT_DLY_CYCLES(DLY), .REPEAT_PER_CYCLES(PER)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .key_sel(key_sel), .key_up(key_up), .key_down(key_down), .key_run(key_run),
        .trig_level(trig_level), .deci_rate(deci_rate), .trig_edge(trig_edge), .v_scale(v_scale),
        .wave_run(wave_run), .sel_item(sel_item), .cfg_update(cfg_update)
    );

    // Advance n cycles, sampling on the falling edge and counting cfg_update pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            if (cfg_update) pulses++;
        end
    endtask

    task automatic press(input logic r, input logic s, input logic u, input logic d);
        {key_run, key_sel, key_up, key_down} = {r, s, u, d};
        step(10);
        {key_run, key_sel, key_up, key_down} = 4'b0000;
        step(10);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        step(3);
        sys_rst_n = 1'b1;
        pulses = 0;
        step(100);
        tests++; if (trig_level !== 8'd127) begin fails++; $display("FAIL reset_trig: got %0d want 127", trig_level); end
        tests++; if (deci_rate !== 10'd1) begin fails++; $display("FAIL reset_deci: got %0d want 1", deci_rate); end
        tests++; if (trig_edge !== 1'b1) begin fails++; $display("FAIL reset_edge: got %b want 1", trig_edge); end
        tests++; if (v_scale !== 5'b10010) begin fails++; $display("FAIL reset_vscale: got %b want 10010", v_scale); end
        tests++; if (wave_run !== 1'b1) begin fails++; $display("FAIL reset_run: got %b want 1", wave_run); end
        tests++; if (sel_item !== 2'd0) begin fails++; $display("FAIL reset_sel: got %0d want 0", sel_item); end
        tests++; if (pulses != 0) begin fails++; $display("FAIL reset_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_glitch_press;
        pulses = 0;
        key_up = 1'b1; step(DEB - 1); key_up = 1'b0;
        step(15);
        tests++; if (trig_level !== 8'd127) begin fails++; $display("FAIL glitch_trig: got %0d want 127", trig_level); end
        tests++; if (pulses != 0) begin fails++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
        key_up = 1'b1;
        step(DEB + 2);
        tests++; if (trig_level !== 8'd127) begin fails++; $display("FAIL latency_early: got %0d want 127", trig_level); end
        step(1);
        tests++; if (trig_level !== 8'd135) begin fails++; $display("FAIL latency_trig: got %0d want 135", trig_level); end
        tests++; if (cfg_update !== 1'b1) begin fails++; $display("FAIL latency_upd: got %b want 1", cfg_update); end
        step(1);
        tests++; if (cfg_update !== 1'b0) begin fails++; $display("FAIL upd_width: got %b want 0", cfg_update); end
        step(2); key_up = 1'b0; step(10);
        tests++; if (pulses != 1) begin fails++; $display("FAIL press_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_saturation;
        pulses = 0;
        repeat (15) press(0, 0, 1, 0);
        tests++; if (trig_level !== 8'd255) begin fails++; $display("FAIL sat_trig: got %0d want 255", trig_level); end
        tests++; if (pulses != 15) begin fails++; $display("FAIL sat_pulses: got %0d want 15", pulses); end
        pulses = 0;
        press(0, 0, 1, 0);
        tests++; if (trig_level !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d want 255", trig_level); end
        tests++; if (pulses != 0) begin fails++; $display("FAIL sat_nopulse: got %0d want 0", pulses); end
        press(0, 1, 0, 0); press(0, 1, 0, 0);
        tests++; if (sel_item !== 2'd2) begin fails++; $display("FAIL sel_edge: got %0d want 2", sel_item); end
        tests++; if (pulses != 0) begin fails++; $display("FAIL sel_nopulse: got %0d want 0", pulses); end
        press(0, 0, 1, 0);
        tests++; if (trig_edge !== 1'b1 || pulses != 0) begin fails++; $display("FAIL edge_same: got %b/%0d want 1/0", trig_edge, pulses); end
        press(0, 0, 0, 1);
        tests++; if (trig_edge !== 1'b0 || pulses != 1) begin fails++; $display("FAIL edge_fall: got %b/%0d want 0/1", trig_edge, pulses); end
        press(0, 0, 1, 0);
        tests++; if (trig_edge !== 1'b1 || pulses != 2) begin fails++; $display("FAIL edge_rise: got %b/%0d want 1/2", trig_edge, pulses); end
    endtask

    task automatic test_deci;
        int         exp_rate [10] = '{2, 5, 10, 20, 50, 100, 200, 500, 1000, 1000};
        logic [4:0] exp_vs [5] = '{5'b10001, 5'b00010, 5'b00100, 5'b01000, 5'b01000};
        press(0, 1, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0);
        tests++; if (sel_item !== 2'd1) begin fails++; $display("FAIL sel_deci: got %0d want 1", sel_item); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            press(0, 0, 1, 0);
            tests++; if (deci_rate !== 10'(exp_rate[i])) begin fails++; $display("FAIL deci_step%0d: got %0d want %0d", i, deci_rate, exp_rate[i]); end
        end
        tests++; if (pulses != 9) begin fails++; $display("FAIL deci_pulses: got %0d want 9", pulses); end
        press(0, 1, 0, 0); press(0, 1, 0, 0);
        tests++; if (sel_item !== 2'd3) begin fails++; $display("FAIL sel_vscale: got %0d want 3", sel_item); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            press(0, 0, 0, 1);
            tests++; if (v_scale !== exp_vs[i]) begin fails++; $display("FAIL vscale_step%0d: got %b want %b", i, v_scale, exp_vs[i]); end
        end
        tests++; if (pulses != 4) begin fails++; $display("FAIL vscale_pulses: got %0d want 4", pulses); end
    endtask

    task automatic test_simultaneous;
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        tests++; if (trig_level !== 8'd247) begin fails++; $display("FAIL trig_down: got %0d want 247", trig_level); end
        pulses = 0;
        press(1, 0, 1, 0);
        tests++; if (wave_run !== 1'b0) begin fails++; $display("FAIL runup_run: got %b want 0", wave_run); end
        tests++; if (trig_level !== 8'd247 || pulses != 1) begin fails++; $display("FAIL runup_trig: got %0d/%0d want 247/1", trig_level, pulses); end
        pulses = 0;
        press(0, 1, 0, 1);
        tests++; if (sel_item !== 2'd1) begin fails++; $display("FAIL seldn_sel: got %0d want 1", sel_item); end
        tests++; if (deci_rate !== 10'd1000 || pulses != 0) begin fails++; $display("FAIL seldn_deci: got %0d/%0d want 1000/0", deci_rate, pulses); end
        press(1, 0, 0, 0);
        tests++; if (wave_run !== 1'b1 || sel_item !== 2'd1) begin fails++; $display("FAIL run_toggle: got %b/%0d want 1/1", wave_run, sel_item); end
    endtask

    task automatic test_repeat;
`ifdef DSO_CTRL_REPEAT_EN
        int exp_trig = 167, exp_pulses = 5;
`else
        int exp_trig = 135, exp_pulses = 1;
`endif
        sys_rst_n = 1'b0; step(2); sys_rst_n = 1'b1; step(10);
        pulses = 0;
        key_up = 1'b1; step(38); key_up = 1'b0; step(20);
        tests++; if (trig_level !== 8'(exp_trig)) begin fails++; $display("FAIL hold_trig: got %0d want %0d", trig_level, exp_trig); end
        tests++; if (pulses != exp_pulses) begin fails++; $display("FAIL hold_pulses: got %0d want %0d", pulses, exp_pulses); end
        key_up = 1'b1; step(30);
        sys_rst_n = 1'b0;
        #1;
        tests++; if (trig_level !== 8'd127 || cfg_update !== 1'b0) begin fails++; $display("FAIL rst_async: got %0d/%b want 127/0", trig_level, cfg_update); end
        step(3);
        sys_rst_n = 1'b1;
        pulses = 0;
        step(40);
        tests++; if (trig_level !== 8'd127 || pulses != 0) begin fails++; $display("FAIL rst_held: got %0d/%0d want 127/0", trig_level, pulses); end
        key_up = 1'b0; step(20);
        tests++; if (trig_level !== 8'd127 || pulses != 0) begin fails++; $display("FAIL rst_release: got %0d/%0d want 127/0", trig_level, pulses); end
        press(0, 0, 1, 0);
        tests++; if (trig_level !== 8'd135 || pulses != 1) begin fails++; $display("FAIL rst_rearm: got %0d/%0d want 135/1", trig_level, pulses); end
    endtask

    initial begin
        test_reset();
        test_glitch_press();
        test_saturation();
        test_deci();
        test_simultaneous();
        test_repeat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dso_ctrl_panel.md
# dso_ctrl_panel

Front-panel controller for the DSO datapath. It debounces four raw push-buttons and runs an item-select state machine. It produces the acquisition and display configuration (trigger level, decimation rate, trigger edge, vertical scale, run/stop) that currently feeds the sampler, decimator, measurement and wave-display blocks as constants. It sits in `dso_top` on the `sys_clk` domain, between the board keys and those consumers.

## Interface
Parameters:
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
- `REPEAT_DLY_CYCLES`, 25_000_000: hold time before auto-repeat starts. Used only with the macro.
- `REPEAT_PER_CYCLES`, 5_000_000: auto-repeat period. Used only with the macro.

Ports:
- `sys_clk`, in, 1: system clock, 50 MHz.
- `sys_rst_n`, in, 1: asynchronous active-low reset.
- `key_sel`, in, 1: raw button, active-high, asynchronous; advances the selected item.
- `key_up`, in, 1: raw button, active-high; increments the selected item.
- `key_down`, in, 1: raw button, active-high; decrements the selected item.
- `key_run`, in, 1: raw button, active-high; toggles run/stop.
- `trig_level`, out, 8: trigger threshold code.
- `deci_rate`, out, 10: decimation rate.
- `trig_edge`, out, 1: 1 = rising edge, 0 = falling edge.
- `v_scale`, out, 5: bit 4: 1 = magnify, 0 = attenuate; bits 3:0 hold the factor.
- `wave_run`, out, 1: 1 = acquisition running.
- `sel_item`, out, 2: currently selected item, for on-screen highlight.
- `cfg_update`, out, 1: one-cycle pulse whenever any configuration output changes value.

## Operation
- Each key passes through a 2-FF synchronizer and then a debounce counter.
  - The counter clears whenever the synchronized level equals the stable level.
  - When the counter reaches `DEB_CYCLES`, the stable level takes the synchronized level.
- A press event is the 0→1 edge of a stable level. Release generates nothing.
- Same-cycle events are resolved by priority: run > sel > up > down. Lower-priority events in that cycle are discarded, not queued.
- `key_run` event: `wave_run` toggles. `sel_item` and all other values are unchanged.
- `sel_item` FSM states: TRIG(0) → DECI(1) → EDGE(2) → VSCALE(3) → TRIG. A `key_sel` event advances one state.
- Up/down events act on the selected item only:
  - TRIG: `trig_level` ±8. Up saturates at 255; down saturates at 0.
  - DECI: a 4-bit index 0..9 maps to rates 1, 2, 5, 10, 20, 50, 100, 200, 500, 1000. Index is ±1 and saturates at both ends.
  - EDGE: up sets `trig_edge` to 1; down sets it to 0.
  - VSCALE: a 3-bit index 0..6 maps to {0,8}, {0,4}, {0,2}, {1,1}, {1,2}, {1,4}, {1,8}. Index is ±1 and saturates at both ends.
- `cfg_update` asserts only if a value actually changes. No pulse for saturated steps, EDGE re-selecting its current value, or `sel_item` changes.

## Timing
- Reset values:
  - `trig_level` = 127.
  - `deci_rate` = 1 (index 0).
  - `trig_edge` = 1.
  - `v_scale` = 5'b10010 (index 4).
  - `wave_run` = 1.
  - `sel_item` = 0.
  - `cfg_update` = 0.
  - All debounce state cleared, stable levels 0.
- Latency: for a raw key held high from cycle 0, the output register updates at cycle `DEB_CYCLES`+3, with `cfg_update` high in that same cycle. Allowed tolerance is ±1 cycle, and the value must be fixed in the implementation.
- Any raw pulse shorter than `DEB_CYCLES` cycles produces no event.
- All outputs are registered. Configuration outputs change at most once per cycle.
- Reset assertion mid-debounce or mid-repeat returns everything to reset values immediately. No event is generated on deassertion, even with keys held.

## Configuration
- `DSO_CTRL_REPEAT_EN` defined: while `key_up` or `key_down` stays stably high, a repeat event is generated `REPEAT_DLY_CYCLES` after the press event, then every `REPEAT_PER_CYCLES`.
  - Repeat events follow the same priority and saturation rules as press events.
  - Repeat stops on stable release or on any other key press event.
- `DSO_CTRL_REPEAT_EN` undefined: exactly one event per press. Repeat counters are not built.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `REPEAT_DLY_CYCLES`=20, `REPEAT_PER_CYCLES`=5.
- Reset check: release reset → outputs 127, 1, 1, 5'b10010, 1, `sel_item` 0, no `cfg_update` for 100 cycles with keys low.
- Glitch and press: `key_up` high 3 cycles → no change. Then `key_up` high 10 cycles → `trig_level` 135, one `cfg_update` pulse.
- Saturation and no-change pulse: 16 up events → `trig_level` 255. A further up event gives no change and no pulse. In EDGE, a `key_up` event while `trig_edge`=1 gives no pulse.
- Decimation walk: `key_sel` once, 10 up events → `deci_rate` follows 2, 5, …, 1000 and holds at 1000. VSCALE down ×5 → {0,8} and holds.
- Simultaneous events: `key_run` and `key_up` rise in the same cycle → `wave_run` 0, `trig_level` unchanged. `key_sel` with `key_down` → `sel_item` advances only.
- Repeat (macro on): hold `key_up` 40 cycles in TRIG → first step at press, second ~20 cycles later, then every 5 cycles. Macro off → one step only. Reset asserted mid-hold → 127, no event after deassertion.
